// File: rtl/wbs_uart_rx_pkg.sv
// Register map, status bit positions and RX FSM state type.
// The register map and status bits are shared with the transmit peripheral.
package wbs_uart_rx_pkg;

  localparam int unsigned UART_RX_DATA   = 0;
  localparam int unsigned UART_RX_STATUS = 1;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_OVERRUN   = 1;
  localparam int unsigned STAT_FRAME_ERR = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes.
// When the FIFO is full, a push is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push_c;
  logic                  do_pop_c;

  assign empty_c   = (count == '0);
  assign full_c    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop_c  = pop && !empty_c;
  assign do_push_c = push && (!full_c || do_pop_c);
  assign head_c    = mem[rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push_c) wptr <= wptr + (DEPTH_LOG2)'(1);
      if (do_pop_c)  rptr <= rptr + (DEPTH_LOG2)'(1);
      unique case ({do_push_c, do_pop_c})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push_c) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wbs_uart_rx.sv
// 8N1 UART receiver with a byte FIFO.
// The FIFO and status flags are accessed through a classic single-cycle Wishbone slave.
module wbs_uart_rx
  import wbs_uart_rx_pkg::*;
#(
  parameter int unsigned TICKS_PER_BAUD  = 5000,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [3:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic       uart_rx,
  output logic       irq
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_BAUD);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(TICKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(TICKS_PER_BAUD - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [1:0]       sync_vld;
  logic             armed;
  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             expired_c;
  logic             start_edge_c;
  logic             push_c;
  logic             ferr_set_c;
  logic             overrun;
  logic             frame_err;
  logic [7:0]       fifo_head_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic             wb_req_c;
  logic             is_status_c;
  logic             pop_c;
  logic             clr_c;
  logic             overrun_set_c;
  logic [7:0]       status_c;
  logic             unused_c;

  assign unused_c = ^{wb_adr_i[3:1], wb_dat_i[7:3], wb_dat_i[0]};

  // Synchroniser plus an arming flag, so that the reset preset can never pose as a real high-to-low edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_sync) armed <= 1'b1;
    end
  end

  assign start_edge_c = armed && rx_prev && !rx_sync;
  assign expired_c    = (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // RX FSM: each bit is sampled at its midpoint using the tick counter.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push_c      = 1'b0;
    ferr_set_c  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (start_edge_c) begin
          state_nxt = RX_START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!expired_c) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (!rx_sync) begin
          state_nxt   = RX_DATA;
          bit_idx_nxt = '0;
          cnt_nxt     = FULL_LOAD;
        end else begin
          state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!expired_c) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          shift_nxt = {rx_sync, shift[7:1]};
          cnt_nxt   = FULL_LOAD;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (!expired_c) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (rx_sync) begin
          push_c    = 1'b1;
          state_nxt = RX_IDLE;
        end else begin
          ferr_set_c = 1'b1;
          state_nxt  = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_sync) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (8)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_c),
    .wdata   (shift),
    .pop     (pop_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign wb_req_c      = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign is_status_c   = (wb_adr_i[0] == 1'(UART_RX_STATUS));
  assign pop_c         = wb_req_c && !wb_we_i && !is_status_c && !fifo_empty_c;
  assign clr_c         = wb_req_c && wb_we_i && is_status_c;
  assign overrun_set_c = push_c && fifo_full_c && !pop_c;

  always_comb begin
    status_c                 = '0;
    status_c[STAT_NOT_EMPTY] = !fifo_empty_c;
    status_c[STAT_OVERRUN]   = overrun;
    status_c[STAT_FRAME_ERR] = frame_err;
  end

  // Sticky error flags; a new error event takes priority over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set_c)                         overrun <= 1'b1;
      else if (clr_c && wb_dat_i[STAT_OVERRUN])  overrun <= 1'b0;
      if (ferr_set_c)                            frame_err <= 1'b1;
      else if (clr_c && wb_dat_i[STAT_FRAME_ERR]) frame_err <= 1'b0;
    end
  end

  // Wishbone response: one ack per request, and read data is captured together with the ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq      <= 1'b0;
    end else begin
      wb_ack_o <= wb_req_c;
      if (wb_req_c) begin
        if (wb_we_i)          wb_dat_o <= '0;
        else if (is_status_c) wb_dat_o <= status_c;
        else if (fifo_empty_c) wb_dat_o <= '0;
        else                  wb_dat_o <= fifo_head_c;
      end
      irq <= !fifo_empty_c || overrun || frame_err;
    end
  end

endmodule

// File: tb/tb_wbs_uart_rx.sv
// Directed bench for wbs_uart_rx: serial frames, register vector table and corner sequences.
module tb_wbs_uart_rx;

  localparam int TPB = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       uart_rx;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] wdat;
    logic [7:0] exp;
    logic       chk;
  } vec_t;

  vec_t t2 [11];

  wbs_uart_rx #(
    .TICKS_PER_BAUD  (TPB),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .uart_rx  (uart_rx),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Called at posedge+1; performs a single transfer and returns at posedge+1.
  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [7:0] wdat,
                         output logic [7:0] rdat);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = wdat;
    @(posedge clock); #1;
    check("ack_high", {7'b0, wb_ack_o}, 8'h01);
    rdat     = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clock); #1;
    check("ack_low", {7'b0, wb_ack_o}, 8'h00);
  endtask

  task automatic rd_check(input string name, input logic [3:0] adr, input logic [7:0] exp);
    logic [7:0] r;
    wb_xfer(1'b0, adr, 8'h00, r);
    check(name, r, exp);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [7:0] d);
    logic [7:0] r;
    wb_xfer(1'b1, adr, d, r);
  endtask

  // One 8N1 frame, LSB first; the stop level and its length are configurable.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int stop_bits);
    @(posedge clock); #1;
    uart_rx = 1'b0;
    repeat (TPB) @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (TPB) @(posedge clock);
      #1;
    end
    uart_rx = stop_lvl;
    repeat (TPB * stop_bits) @(posedge clock);
    #1;
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    int         acks;
    logic [7:0] bits99;

    t2[0]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b1};
    t2[1]  = '{1'b0, 4'h0, 8'h00, 8'hFF, 1'b1};
    t2[2]  = '{1'b0, 4'h0, 8'h00, 8'h3C, 1'b1};
    t2[3]  = '{1'b0, 4'h0, 8'h00, 8'h81, 1'b1};
    t2[4]  = '{1'b0, 4'h1, 8'h00, 8'h02, 1'b1};
    t2[5]  = '{1'b1, 4'h1, 8'h02, 8'h00, 1'b0};
    t2[6]  = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b1};
    t2[7]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b1};
    t2[8]  = '{1'b1, 4'h0, 8'h55, 8'h00, 1'b0};
    t2[9]  = '{1'b0, 4'h1, 8'h00, 8'h00, 1'b1};
    t2[10] = '{1'b0, 4'hF, 8'h00, 8'h00, 1'b1};

    reset    = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = 4'h0;
    wb_dat_i = 8'h00;
    uart_rx  = 1'b1;
    idle(3);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_ack", {7'b0, wb_ack_o}, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    reset = 1'b0;
    idle(8);
    rd_check("rst_status", 4'h1, 8'h00);

    // 1: single byte
    send_byte(8'hA5, 1'b1, 1);
    idle(2);
    check("t1_irq_set", {7'b0, irq}, 8'h01);
    rd_check("t1_status", 4'h1, 8'h01);
    rd_check("t1_data", 4'h0, 8'hA5);
    rd_check("t1_status_empty", 4'h1, 8'h00);
    check("t1_irq_clr", {7'b0, irq}, 8'h00);

    // back-to-back strobes are acked every other cycle
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("b2b_acks", 8'(acks), 8'h02);
    idle(2);

    // 2: overrun with a full FIFO, then the register vector table
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    send_byte(8'h81, 1'b1, 1);
    send_byte(8'h42, 1'b1, 1);
    idle(4);
    for (int i = 0; i < 11; i++) begin
      wb_xfer(t2[i].we, t2[i].adr, t2[i].wdat, rd);
      if (t2[i].chk) check($sformatf("t2_vec%0d", i), rd, t2[i].exp);
    end

    // 3: framing error with a long low stop bit, then recovery
    send_byte(8'h55, 1'b0, 3);
    idle(4);
    rd_check("t3_status_ferr", 4'h1, 8'h04);
    check("t3_irq", {7'b0, irq}, 8'h01);
    rd_check("t3_fifo_empty", 4'h0, 8'h00);
    wr(4'h1, 8'h04);
    rd_check("t3_status_clr", 4'h1, 8'h00);
    send_byte(8'h12, 1'b1, 1);
    idle(2);
    rd_check("t3_data", 4'h0, 8'h12);

    // 4: short glitch on an idle line
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(3 * TPB);
    rd_check("t4_status", 4'h1, 8'h00);
    check("t4_irq", {7'b0, irq}, 8'h00);
    send_byte(8'h7E, 1'b1, 1);
    idle(2);
    rd_check("t4_status_byte", 4'h1, 8'h01);

    // 5: reset during data bit 3 of 0x99, with the line held low after reset
    bits99  = 8'h99;
    uart_rx = 1'b0;
    idle(TPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = bits99[i];
      idle(TPB);
    end
    uart_rx = bits99[3];
    idle(TPB / 2);
    reset   = 1'b1;
    uart_rx = 1'b0;
    idle(2);
    reset = 1'b0;
    check("t5_dat", wb_dat_o, 8'h00);
    check("t5_ack", {7'b0, wb_ack_o}, 8'h00);
    check("t5_irq", {7'b0, irq}, 8'h00);
    idle(2 * TPB);
    uart_rx = 1'b1;
    idle(TPB);
    rd_check("t5_status", 4'h1, 8'h00);
    send_byte(8'h66, 1'b1, 1);
    idle(2);
    rd_check("t5_data", 4'h0, 8'h66);

    // 6: pop lands on the same cycle as a push, with one entry queued
    send_byte(8'h11, 1'b1, 1);
    idle(2);
    fork
      send_byte(8'h22, 1'b1, 1);
      begin
        repeat (TPB / 2 + 9 * TPB + 3) @(posedge clock);
        #1;
        wb_xfer(1'b0, 4'h0, 8'h00, rd);
        check("t6_old_head", rd, 8'h11);
      end
    join
    idle(2);
    rd_check("t6_status", 4'h1, 8'h01);
    rd_check("t6_new", 4'h0, 8'h22);
    rd_check("t6_status_empty", 4'h1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
